// File: rtl/ks_adder_pkg.sv
// Shared definitions for the pipelined Kogge-Stone adder/subtractor.
// Holds the prefix-level count helper and the add/subtract opcode encoding.
package ks_adder_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // The carry-in occupies an extra bit below the LSB, so W+1 positions need prefix coverage.
    function automatic int ks_levels(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/ks_prefix_level.sv
// One combinational Kogge-Stone prefix level of span D over a W+1 bit G/P vector.
// Bit 0 of the vectors is the folded-in carry-in; operand bit i lives at index i+1.
module ks_prefix_level
    import ks_adder_pkg::*;
#(
    parameter int W = 8,
    parameter int D = 1
)
(
    input  logic [W:0] i_gen,
    input  logic [W:0] i_prop,
    output logic [W:0] o_gen,
    output logic [W:0] o_prop
);

    // Positions whose partner lies below the carry-in bit have already resolved and pass through.
    for (genvar j = 0; j <= W; j++) begin : g_bit
        if (j >= D) begin : g_comb
            assign o_gen[j]  = i_gen[j] | (i_prop[j] & i_gen[j-D]);
            assign o_prop[j] = i_prop[j] & i_prop[j-D];
        end else begin : g_pass
            assign o_gen[j]  = i_gen[j];
            assign o_prop[j] = i_prop[j];
        end
    end

endmodule

// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready flow control and a sideband tag.
// Optional signed overflow output is enabled by defining KS_ADDER_OVF_EN.
module ks_adder_pipe
    import ks_adder_pkg::*;
#(
    parameter int W     = 32,
    parameter int TAG_W = 4
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic             ci,
    input  logic             sub,
    input  logic [TAG_W-1:0] tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     s,
    output logic             co,
`ifdef KS_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic [TAG_W-1:0] out_tag
);

    localparam int L = ks_levels(W);

    logic             w_adv;
    logic [W-1:0]     w_bEff;
    logic             w_cEff;
    logic [W-1:0]     w_sumNext;
    logic [W:0]       w_genNext  [L];
    logic [W:0]       w_propNext [L];

    logic [W:0]       r_gen   [L+1];
    logic [W:0]       r_prop  [L];
    logic [W-1:0]     r_p0    [L+1];
    logic [TAG_W-1:0] r_tag   [L+1];
    logic [L:0]       r_valid;

    logic [W-1:0]     r_s;
    logic             r_co;
    logic [TAG_W-1:0] r_outTag;
    logic             r_outValid;

    // One global enable: the whole pipe freezes while a result waits downstream.
    assign w_adv    = !r_outValid || out_ready;
    assign in_ready = w_adv;

    assign w_bEff    = (sub == OP_SUB) ? ~b  : b;
    assign w_cEff    = (sub == OP_SUB) ? ~ci : ci;
    assign w_sumNext = r_p0[L] ^ r_gen[L][W-1:0];

    assign out_valid = r_outValid;
    assign s         = r_s;
    assign co        = r_co;
    assign out_tag   = r_outTag;

    for (genvar k = 0; k < L; k++) begin : g_level
        ks_prefix_level #(
            .W (W),
            .D (1 << k)
        ) u_level (
            .i_gen  (r_gen[k]),
            .i_prop (r_prop[k]),
            .o_gen  (w_genNext[k]),
            .o_prop (w_propNext[k])
        );
    end

    // The final level's propagate is never needed, so r_prop stops one stage short of r_gen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= '0;
            r_outValid <= 1'b0;
            r_s        <= '0;
            r_co       <= 1'b0;
            r_outTag   <= '0;
            for (int k = 0; k <= L; k++) begin
                r_gen[k] <= '0;
                r_p0[k]  <= '0;
                r_tag[k] <= '0;
            end
            for (int k = 0; k < L; k++) begin
                r_prop[k] <= '0;
            end
        end else if (w_adv) begin
            r_valid   <= {r_valid[L-1:0], in_valid};
            r_gen[0]  <= {a & w_bEff, w_cEff};
            r_prop[0] <= {a ^ w_bEff, 1'b0};
            r_p0[0]   <= a ^ w_bEff;
            r_tag[0]  <= tag;
            for (int k = 0; k < L; k++) begin
                r_gen[k+1] <= w_genNext[k];
                r_p0[k+1]  <= r_p0[k];
                r_tag[k+1] <= r_tag[k];
            end
            for (int k = 0; k < L - 1; k++) begin
                r_prop[k+1] <= w_propNext[k];
            end
            r_outValid <= r_valid[L];
            r_s        <= w_sumNext;
            r_co       <= r_gen[L][W];
            r_outTag   <= r_tag[L];
        end
    end

`ifdef KS_ADDER_OVF_EN
    logic [L:0] r_xMsb;
    logic       r_ovf;
    logic       w_carryMsb;

    // Carry into the MSB is recovered from the sum bit and the MSB half-sum.
    assign w_carryMsb = r_xMsb[L] ^ w_sumNext[W-1];
    assign ovf        = r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xMsb <= '0;
            r_ovf  <= 1'b0;
        end else if (w_adv) begin
            r_xMsb <= {r_xMsb[L-1:0], a[W-1] ^ w_bEff[W-1]};
            r_ovf  <= w_carryMsb ^ r_gen[L][W];
        end
    end
`endif

endmodule

// File: tb/tb_ks_adder_pipe.sv
// Self-checking bench for ks_adder_pipe: a W=8 instance with a queue-based reference
// model and a W=13 instance for non-power-of-two width and overflow cases.
module tb_ks_adder_pipe;

    localparam int TW = 4;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        in_valid8, in_ready8, ci8, sub8, out_valid8, out_ready8, co8;
    logic [7:0]  a8, b8, s8;
    logic [3:0]  tag8, out_tag8;

    logic        in_valid13, in_ready13, ci13, sub13, out_valid13, out_ready13, co13;
    logic [12:0] a13, b13, s13;
    logic [3:0]  tag13, out_tag13;
`ifdef KS_ADDER_OVF_EN
    logic        ovf8, ovf13;
`endif

    typedef struct {
        logic [7:0] s;
        logic       co;
        logic       ovf;
        logic [3:0] tag;
    } exp8_t;

    exp8_t q8[$];
    exp8_t e8;
    int total = 0;
    int bad = 0;
    int txCount = 0;
    int rxCount = 0;

    always #5 clk = ~clk;

    ks_adder_pipe #(.W(8), .TAG_W(TW)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .ci(ci8), .sub(sub8), .tag(tag8),
        .out_valid(out_valid8), .out_ready(out_ready8), .s(s8), .co(co8),
`ifdef KS_ADDER_OVF_EN
        .ovf(ovf8),
`endif
        .out_tag(out_tag8)
    );

    ks_adder_pipe #(.W(13), .TAG_W(TW)) dut13 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid13), .in_ready(in_ready13),
        .a(a13), .b(b13), .ci(ci13), .sub(sub13), .tag(tag13),
        .out_valid(out_valid13), .out_ready(out_ready13), .s(s13), .co(co13),
`ifdef KS_ADDER_OVF_EN
        .ovf(ovf13),
`endif
        .out_tag(out_tag13)
    );

    // Reference: W+1 bit result of a + b_eff + c_eff using plain integer arithmetic.
    function automatic longint unsigned refSum(input int w, input longint unsigned x,
                                               input longint unsigned y, input bit c, input bit isSub);
        longint unsigned mask = (64'd1 << w) - 1;
        longint unsigned yEff = isSub ? (~y & mask) : (y & mask);
        longint unsigned cEff = (isSub ? !c : c) ? 64'd1 : 64'd0;
        return (x & mask) + yEff + cEff;
    endfunction

    // Reference: signed overflow when the two's-complement sum leaves the W-bit range.
    function automatic bit refOvf(input int w, input longint x, input longint y, input bit c, input bit isSub);
        longint full = longint'(1) << w;
        longint half = longint'(1) << (w - 1);
        longint yEff = isSub ? ((~y) & (full - 1)) : y;
        longint sx   = (x >= half) ? x - full : x;
        longint sy   = (yEff >= half) ? yEff - full : yEff;
        longint cEff = (isSub ? !c : c) ? 1 : 0;
        longint r    = sx + sy + cEff;
        return (r >= half) || (r < -half);
    endfunction

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, obs, expv);
        end
    endtask

    // Drive one W=8 operation from a negedge and wait (bounded) for it to be accepted.
    task automatic applyStimulus(input logic [7:0] aIn, input logic [7:0] bIn, input logic ciIn,
                                 input logic subIn, input logic [3:0] tagIn);
        bit acc = 1'b0;
        longint unsigned r;
        exp8_t e;
        a8 = aIn; b8 = bIn; ci8 = ciIn; sub8 = subIn; tag8 = tagIn; in_valid8 = 1'b1;
        for (int n = 0; n < 40 && !acc; n++) begin
            #1;
            acc = in_ready8;
            @(posedge clk);
            if (acc) begin
                r     = refSum(8, aIn, bIn, ciIn, subIn);
                e.s   = r[7:0];
                e.co  = r[8];
                e.ovf = refOvf(8, aIn, bIn, ciIn, subIn);
                e.tag = tagIn;
                q8.push_back(e);
                txCount++;
            end
            @(negedge clk);
        end
        check("accept8", acc, 1);
    endtask

    // Output monitor for W=8: a transfer happens on the next posedge when valid & ready.
    always begin
        @(negedge clk);
        #2;
        if (rst_n && out_valid8 && out_ready8) begin
            check("out8_expected", q8.size() > 0, 1);
            if (q8.size() > 0) begin
                e8 = q8.pop_front();
                check("out8_s", s8, e8.s);
                check("out8_co", co8, e8.co);
                check("out8_tag", out_tag8, e8.tag);
`ifdef KS_ADDER_OVF_EN
                check("out8_ovf", ovf8, e8.ovf);
`endif
                rxCount++;
            end
        end
    end

    task automatic waitOut8();
        for (int n = 0; n < 30 && !out_valid8; n++) @(negedge clk);
        check("wait_out8", out_valid8, 1);
    endtask

    task automatic drain8();
        for (int n = 0; n < 40 && q8.size() > 0; n++) @(negedge clk);
        check("drain8_empty", q8.size(), 0);
        check("drain8_count", rxCount, txCount);
    endtask

    // One W=13 operation; returns at the negedge where its result is presented.
    task automatic checkOutput13(input logic [12:0] aIn, input logic [12:0] bIn,
                                 input logic ciIn, input logic subIn, input logic [3:0] tagIn);
        longint unsigned r = refSum(13, aIn, bIn, ciIn, subIn);
        a13 = aIn; b13 = bIn; ci13 = ciIn; sub13 = subIn; tag13 = tagIn; in_valid13 = 1'b1;
        #1;
        check("in_ready13", in_ready13, 1);
        @(negedge clk);
        in_valid13 = 1'b0;
        for (int n = 0; n < 30 && !out_valid13; n++) @(negedge clk);
        check("wait_out13", out_valid13, 1);
        check("out13_s", s13, r[12:0]);
        check("out13_co", co13, r[13]);
        check("out13_tag", out_tag13, tagIn);
`ifdef KS_ADDER_OVF_EN
        check("out13_ovf", ovf13, refOvf(13, aIn, bIn, ciIn, subIn));
`endif
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] holdS;
        logic [3:0] holdTag;
        logic       holdCo;
        int         seen;

        rst_n = 1'b0;
        in_valid8 = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0; sub8 = 1'b0; tag8 = '0; out_ready8 = 1'b1;
        in_valid13 = 1'b0; a13 = '0; b13 = '0; ci13 = 1'b0; sub13 = 1'b0; tag13 = '0; out_ready13 = 1'b1;
        #1;
        check("rst_out_valid", out_valid8, 0);
        check("rst_in_ready", in_ready8, 1);
        check("rst_s", s8, 0);
        check("rst_co", co8, 0);
        check("rst_tag", out_tag8, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Latency: 0xFF + 0x01 appears exactly 5 cycles after acceptance.
        applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0, 4'h3);
        in_valid8 = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check($sformatf("lat8_valid_%0d", k), out_valid8, k == 5);
        end
        check("lat8_s", s8, 8'h00);
        check("lat8_co", co8, 1);
        check("lat8_tag", out_tag8, 4'h3);
        @(negedge clk);

        // Subtract pair, issued back to back.
        applyStimulus(8'h05, 8'h07, 1'b0, 1'b1, 4'h1);
        applyStimulus(8'h07, 8'h05, 1'b1, 1'b1, 4'h2);
        in_valid8 = 1'b0;
        waitOut8();
        check("sub1_s", s8, 8'hFE);
        check("sub1_co", co8, 0);
        @(negedge clk);
        check("sub2_valid", out_valid8, 1);
        check("sub2_s", s8, 8'h01);
        check("sub2_co", co8, 1);
        drain8();

        // Back-to-back random traffic with out_ready held high.
        for (int i = 0; i < 16; i++) begin
            check("b2b_in_ready", in_ready8, 1);
            applyStimulus(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 4'($urandom));
        end
        in_valid8 = 1'b0;
        drain8();

        // Backpressure: stall a valid result for 3 cycles.
        for (int i = 0; i < 4; i++)
            applyStimulus(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 4'(i + 8));
        in_valid8 = 1'b0;
        waitOut8();
        out_ready8 = 1'b0;
        #1;
        check("bp_in_ready_comb", in_ready8, 0);
        holdS = s8; holdTag = out_tag8; holdCo = co8;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_in_ready", in_ready8, 0);
            check("bp_valid", out_valid8, 1);
            check("bp_s_stable", s8, holdS);
            check("bp_co_stable", co8, holdCo);
            check("bp_tag_stable", out_tag8, holdTag);
        end
        out_ready8 = 1'b1;
        drain8();

        // Reset with one result presented and two more in flight.
        for (int i = 0; i < 3; i++)
            applyStimulus(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 4'($urandom));
        in_valid8 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mid_pre_valid", out_valid8, 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", out_valid8, 0);
        check("rst_mid_in_ready", in_ready8, 1);
        check("rst_mid_s", s8, 0);
        check("rst_mid_tag", out_tag8, 0);
        q8.delete();
        txCount = rxCount;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (out_valid8) seen++;
        end
        check("rst_no_stale", seen, 0);

        // W=13 boundary cases, then a few random operations.
        checkOutput13(13'h0FFF, 13'h0001, 1'b0, 1'b0, 4'h5);
        check("w13_add_s", s13, 13'h1000);
`ifdef KS_ADDER_OVF_EN
        check("w13_add_ovf", ovf13, 1);
`endif
        @(negedge clk);
        checkOutput13(13'h1000, 13'h0001, 1'b0, 1'b1, 4'h6);
        check("w13_sub_s", s13, 13'h0FFF);
`ifdef KS_ADDER_OVF_EN
        check("w13_sub_ovf", ovf13, 1);
`endif
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput13(13'($urandom), 13'($urandom), 1'($urandom), 1'($urandom), 4'($urandom));
        end

        @(negedge clk);
        check("final_count8", rxCount, txCount);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
